// File: rtl/key_irq_pkg.sv
// Shared constants, FSM state type and priority encoder for the key interrupt controller.
package key_irq_pkg;

  localparam int          NUM_KEYS          = 9;
  localparam logic [7:0]  VECTOR_BASE_DEF   = 8'h15;
  localparam logic [15:0] LOCKOUT_TICKS_DEF = 16'd512;

  localparam logic [23:0] EN_ADDR      = 24'h2024;
  localparam logic [23:0] CFG_ADDR     = 24'h2025;
  localparam logic [23:0] PEND_ADDR    = 24'h2028;
  localparam logic [23:0] PEND_HI_ADDR = 24'h2029;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  // Index of the lowest set bit; key 0 has the highest priority.
  function automatic logic [3:0] lowest_set(input logic [NUM_KEYS-1:0] v);
    lowest_set = 4'd0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = 4'(i);
    end
  endfunction

endpackage

// File: rtl/key_irq_lockout.sv
// Single-key lockout: after an accepted pulse, further pulses are ignored until the counter runs out.
// Latency: combinational accept. Backpressure: none; rejected pulses are dropped.
module key_irq_lockout
  import key_irq_pkg::*;
#(
  parameter logic [15:0] LOCKOUT_TICKS = LOCKOUT_TICKS_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_ce,
  input  logic i_pulse,
  output logic o_accept
);

  logic [15:0] r_cnt;

  // A count of 1 reaches 0 on this tick, so a pulse arriving now is already allowed.
  assign o_accept = i_pulse && (r_cnt <= 16'd1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= 16'd0;
    end else if (i_ce) begin
      if (o_accept) r_cnt <= LOCKOUT_TICKS;
      else if (r_cnt != 16'd0) r_cnt <= r_cnt - 16'd1;
    end
  end

endmodule

// File: rtl/key_irq_ctrl.sv
// Key interrupt controller: pending/enable/level registers, fixed-priority pick, req/ack to CPU.
// Latency: key pulse on tick N -> pending on N+1 -> irq_req on N+2. Backpressure: request held until ack or abort.
// Optional per-key pulse lockout with KEY_IRQ_LOCKOUT_EN.
module key_irq_ctrl
  import key_irq_pkg::*;
#(
  parameter logic [7:0]  VECTOR_BASE   = VECTOR_BASE_DEF
`ifdef KEY_IRQ_LOCKOUT_EN
  , parameter logic [15:0] LOCKOUT_TICKS = LOCKOUT_TICKS_DEF
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_ce,
  input  logic [8:0]  key_irqs,
  input  logic [23:0] bus_address_in,
  input  logic [7:0]  bus_data_in,
  input  logic        bus_write,
  output logic [7:0]  bus_data_out,
  output logic        irq_req,
  output logic [7:0]  irq_vector,
  output logic [1:0]  irq_level,
  input  logic        irq_ack
);

  logic [NUM_KEYS-1:0] r_en, r_pend;
  logic [1:0]          r_lvl;
  state_t              r_state;
  logic [3:0]          r_sel;
  logic                r_req;
  logic [7:0]          r_vec;
  logic [1:0]          r_lvl_out;

  logic [NUM_KEYS-1:0] w_accept, w_set, w_clr, w_en_nxt, w_pend_nxt, w_elig;
  logic [1:0]          w_lvl_nxt;
  logic [3:0]          w_win;
  logic                w_wr_en, w_wr_cfg, w_wr_pend, w_wr_pend_hi;
  state_t              w_state_nxt;
  logic                w_load, w_drop;

`ifdef KEY_IRQ_LOCKOUT_EN
  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_lock
    key_irq_lockout #(.LOCKOUT_TICKS(LOCKOUT_TICKS)) u_lock (
      .i_clk    (clk),
      .i_rst    (reset),
      .i_ce     (clk_ce),
      .i_pulse  (key_irqs[gi]),
      .o_accept (w_accept[gi])
    );
  end
`else
  assign w_accept = key_irqs;
`endif

  assign w_wr_en      = clk_ce && bus_write && (bus_address_in == EN_ADDR);
  assign w_wr_cfg     = clk_ce && bus_write && (bus_address_in == CFG_ADDR);
  assign w_wr_pend    = clk_ce && bus_write && (bus_address_in == PEND_ADDR);
  assign w_wr_pend_hi = clk_ce && bus_write && (bus_address_in == PEND_HI_ADDR);

  assign w_set = clk_ce ? w_accept : '0;
  assign w_clr = {w_wr_pend_hi & bus_data_in[0], w_wr_pend ? bus_data_in : 8'h00};
  // OR-ing the set after the clear makes a simultaneous pulse win over W1C.
  assign w_pend_nxt = (r_pend & ~w_clr) | w_set;

  always_comb begin
    w_en_nxt  = r_en;
    w_lvl_nxt = r_lvl;
    if (w_wr_en) w_en_nxt[7:0] = bus_data_in;
    if (w_wr_cfg) begin
      w_en_nxt[8] = bus_data_in[0];
      w_lvl_nxt   = bus_data_in[2:1];
    end
  end

  assign w_elig = r_pend & r_en;
  assign w_win  = lowest_set(w_elig);

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_drop      = 1'b0;
    if (clk_ce) begin
      case (r_state)
        IDLE: begin
          if ((w_elig != '0) && (r_lvl != 2'd0)) begin
            w_state_nxt = REQ;
            w_load      = 1'b1;
          end
        end
        REQ: begin
          // Abort looks at this tick's writes so that an ack on the same tick can win.
          if (irq_ack) begin
            w_state_nxt = SERVICE;
            w_drop      = 1'b1;
          end else if (!w_pend_nxt[r_sel] || !w_en_nxt[r_sel] || (w_lvl_nxt == 2'd0)) begin
            w_state_nxt = IDLE;
            w_drop      = 1'b1;
          end
        end
        SERVICE: begin
          if (!r_pend[r_sel]) w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_en      <= '0;
      r_pend    <= '0;
      r_lvl     <= 2'd0;
      r_state   <= IDLE;
      r_sel     <= 4'd0;
      r_req     <= 1'b0;
      r_vec     <= 8'h00;
      r_lvl_out <= 2'd0;
    end else if (clk_ce) begin
      r_en    <= w_en_nxt;
      r_pend  <= w_pend_nxt;
      r_lvl   <= w_lvl_nxt;
      r_state <= w_state_nxt;
      if (w_load) begin
        r_req     <= 1'b1;
        r_sel     <= w_win;
        r_vec     <= VECTOR_BASE + {4'd0, w_win};
        r_lvl_out <= r_lvl;
      end else if (w_drop) begin
        r_req <= 1'b0;
      end
    end
  end

  always_comb begin
    bus_data_out = 8'h00;
    case (bus_address_in)
      EN_ADDR:      bus_data_out = r_en[7:0];
      CFG_ADDR:     bus_data_out = {5'd0, r_lvl, r_en[8]};
      PEND_ADDR:    bus_data_out = r_pend[7:0];
      PEND_HI_ADDR: bus_data_out = {7'd0, r_pend[8]};
      default:      bus_data_out = 8'h00;
    endcase
  end

  assign irq_req    = r_req;
  assign irq_vector = r_vec;
  assign irq_level  = r_lvl_out;

endmodule

// File: tb/tb_key_irq_ctrl.sv
// Bench for key_irq_ctrl: table of per-tick vectors plus hand sequences for abort, collision and reset.
module tb_key_irq_ctrl;
  import key_irq_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_ce = 1'b1;
  logic [8:0]  key_irqs = '0;
  logic [23:0] bus_address_in = '0;
  logic [7:0]  bus_data_in = '0;
  logic        bus_write = 1'b0;
  logic [7:0]  bus_data_out;
  logic        irq_req;
  logic [7:0]  irq_vector;
  logic [1:0]  irq_level;
  logic        irq_ack = 1'b0;

  always #5 clk = ~clk;

  key_irq_ctrl #(
    .VECTOR_BASE(8'h15)
`ifdef KEY_IRQ_LOCKOUT_EN
    , .LOCKOUT_TICKS(16'd4)
`endif
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .clk_ce         (clk_ce),
    .key_irqs       (key_irqs),
    .bus_address_in (bus_address_in),
    .bus_data_in    (bus_data_in),
    .bus_write      (bus_write),
    .bus_data_out   (bus_data_out),
    .irq_req        (irq_req),
    .irq_vector     (irq_vector),
    .irq_level      (irq_level),
    .irq_ack        (irq_ack)
  );

  typedef struct {
    string       name;
    logic [8:0]  keys;
    logic        wr;
    logic [23:0] addr;
    logic [7:0]  data;
    logic        ack;
    logic        ce;
    logic        req;
    logic [7:0]  vec;
    logic [1:0]  lvl;
    logic [7:0]  rd;
  } vec_t;

  typedef struct {
    string      name;
    logic       req;
    logic [7:0] vec;
    logic [1:0] lvl;
    logic [7:0] rd;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;
  vec_t tbl[28];

  task automatic chk(input string name, input string what, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s.%s: got %02h expected %02h", name, what, act, exp);
  endtask

  function automatic vec_t mk(input string name, input logic [8:0] keys, input logic wr,
                              input logic [23:0] addr, input logic [7:0] data, input logic ack,
                              input logic req, input logic [7:0] vec, input logic [1:0] lvl,
                              input logic [7:0] rd);
    vec_t v;
    v.name = name; v.keys = keys; v.wr = wr; v.addr = addr; v.data = data; v.ack = ack;
    v.ce = 1'b1; v.req = req; v.vec = vec; v.lvl = lvl; v.rd = rd;
    return v;
  endfunction

  // Drive one tick of stimulus, queue its expectation, then compare after the edge.
  task automatic step(input vec_t v);
    exp_t e;
    key_irqs = v.keys; bus_write = v.wr; bus_address_in = v.addr;
    bus_data_in = v.data; irq_ack = v.ack; clk_ce = v.ce;
    sb.push_back('{v.name, v.req, v.vec, v.lvl, v.rd});
    @(posedge clk); #1;
    key_irqs = '0; bus_write = 1'b0; irq_ack = 1'b0; clk_ce = 1'b1;
    e = sb.pop_front();
    chk(e.name, "irq_req", {7'd0, irq_req}, {7'd0, e.req});
    chk(e.name, "irq_vector", irq_vector, e.vec);
    chk(e.name, "irq_level", {6'd0, irq_level}, {6'd0, e.lvl});
    chk(e.name, "bus_data_out", bus_data_out, e.rd);
  endtask

  task automatic read_chk(input string name, input logic [23:0] addr, input logic [7:0] exp);
    bus_address_in = addr;
    #1;
    chk(name, "bus_data_out", bus_data_out, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t v;
    tbl[0]  = mk("en_ff",   9'h000, 1, EN_ADDR,      8'hFF, 0, 0, 8'h00, 2'd0, 8'hFF);
    tbl[1]  = mk("cfg_05",  9'h000, 1, CFG_ADDR,     8'h05, 0, 0, 8'h00, 2'd0, 8'h05);
    tbl[2]  = mk("key3",    9'h008, 0, PEND_ADDR,    8'h00, 0, 0, 8'h00, 2'd0, 8'h08);
    tbl[3]  = mk("req3",    9'h000, 0, PEND_ADDR,    8'h00, 0, 1, 8'h18, 2'd2, 8'h08);
    tbl[4]  = mk("ack3",    9'h000, 0, PEND_ADDR,    8'h00, 1, 0, 8'h18, 2'd2, 8'h08);
    tbl[5]  = mk("svc3",    9'h000, 0, PEND_ADDR,    8'h00, 0, 0, 8'h18, 2'd2, 8'h08);
    tbl[6]  = mk("clr3",    9'h000, 1, PEND_ADDR,    8'h08, 0, 0, 8'h18, 2'd2, 8'h00);
    tbl[7]  = mk("idle3",   9'h000, 0, PEND_ADDR,    8'h00, 0, 0, 8'h18, 2'd2, 8'h00);
    tbl[8]  = mk("k5k1",    9'h022, 0, PEND_ADDR,    8'h00, 0, 0, 8'h18, 2'd2, 8'h22);
    tbl[9]  = mk("req1",    9'h000, 0, PEND_ADDR,    8'h00, 0, 1, 8'h16, 2'd2, 8'h22);
    tbl[10] = mk("frozen",  9'h001, 0, PEND_ADDR,    8'h00, 0, 1, 8'h16, 2'd2, 8'h23);
    tbl[11] = mk("ack1",    9'h000, 0, PEND_ADDR,    8'h00, 1, 0, 8'h16, 2'd2, 8'h23);
    tbl[12] = mk("clr01",   9'h000, 1, PEND_ADDR,    8'h03, 0, 0, 8'h16, 2'd2, 8'h20);
    tbl[13] = mk("svc_out", 9'h000, 0, PEND_ADDR,    8'h00, 0, 0, 8'h16, 2'd2, 8'h20);
    tbl[14] = mk("req5",    9'h000, 0, PEND_ADDR,    8'h00, 0, 1, 8'h1A, 2'd2, 8'h20);
    tbl[15] = mk("ack5",    9'h000, 0, PEND_ADDR,    8'h00, 1, 0, 8'h1A, 2'd2, 8'h20);
    tbl[16] = mk("clr5",    9'h000, 1, PEND_ADDR,    8'h20, 0, 0, 8'h1A, 2'd2, 8'h00);
    tbl[17] = mk("idle5",   9'h000, 0, PEND_ADDR,    8'h00, 0, 0, 8'h1A, 2'd2, 8'h00);
    tbl[18] = mk("en_00",   9'h000, 1, EN_ADDR,      8'h00, 0, 0, 8'h1A, 2'd2, 8'h00);
    tbl[19] = mk("cfg_04",  9'h000, 1, CFG_ADDR,     8'h04, 0, 0, 8'h1A, 2'd2, 8'h04);
    tbl[20] = mk("key8",    9'h100, 0, PEND_HI_ADDR, 8'h00, 0, 0, 8'h1A, 2'd2, 8'h01);
    tbl[21] = mk("masked",  9'h000, 0, PEND_HI_ADDR, 8'h00, 0, 0, 8'h1A, 2'd2, 8'h01);
    tbl[22] = mk("cfg_05b", 9'h000, 1, CFG_ADDR,     8'h05, 0, 0, 8'h1A, 2'd2, 8'h05);
    tbl[23] = mk("req8",    9'h000, 0, PEND_HI_ADDR, 8'h00, 0, 1, 8'h1D, 2'd2, 8'h01);
    tbl[24] = mk("lvl_chg", 9'h000, 1, CFG_ADDR,     8'h03, 0, 1, 8'h1D, 2'd2, 8'h03);
    tbl[25] = mk("ack8",    9'h000, 0, PEND_HI_ADDR, 8'h00, 1, 0, 8'h1D, 2'd2, 8'h01);
    tbl[26] = mk("clr8",    9'h000, 1, PEND_HI_ADDR, 8'h01, 0, 0, 8'h1D, 2'd2, 8'h00);
    tbl[27] = mk("idle8",   9'h000, 0, PEND_HI_ADDR, 8'h00, 0, 0, 8'h1D, 2'd2, 8'h00);

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset", "irq_req", {7'd0, irq_req}, 8'h00);
    chk("reset", "irq_vector", irq_vector, 8'h00);
    chk("reset", "irq_level", {6'd0, irq_level}, 8'h00);
    read_chk("reset_en", EN_ADDR, 8'h00);
    read_chk("reset_cfg", CFG_ADDR, 8'h00);

    for (int i = 0; i < 28; i++) step(tbl[i]);

    // Abort by W1C without ack; then ack colliding with an enable-clear abort.
    step(mk("ab_en",    9'h000, 1, EN_ADDR,   8'hFF, 0, 0, 8'h1D, 2'd2, 8'hFF));
    step(mk("ab_key2",  9'h004, 0, PEND_ADDR, 8'h00, 0, 0, 8'h1D, 2'd2, 8'h04));
    step(mk("ab_req2",  9'h000, 0, PEND_ADDR, 8'h00, 0, 1, 8'h17, 2'd1, 8'h04));
    step(mk("ab_clr",   9'h000, 1, PEND_ADDR, 8'h04, 0, 0, 8'h17, 2'd1, 8'h00));
    step(mk("ab_idle",  9'h000, 0, 24'h0,     8'h00, 0, 0, 8'h17, 2'd1, 8'h00));
    step(mk("aa_key2",  9'h004, 0, PEND_ADDR, 8'h00, 0, 0, 8'h17, 2'd1, 8'h04));
    step(mk("aa_req2",  9'h000, 0, PEND_ADDR, 8'h00, 0, 1, 8'h17, 2'd1, 8'h04));
    step(mk("aa_ack",   9'h000, 1, EN_ADDR,   8'h00, 1, 0, 8'h17, 2'd1, 8'h00));
    step(mk("aa_reen",  9'h000, 1, EN_ADDR,   8'hFF, 0, 0, 8'h17, 2'd1, 8'hFF));
    step(mk("aa_svc1",  9'h000, 0, PEND_ADDR, 8'h00, 0, 0, 8'h17, 2'd1, 8'h04));
    step(mk("aa_svc2",  9'h000, 0, PEND_ADDR, 8'h00, 0, 0, 8'h17, 2'd1, 8'h04));
    step(mk("svc_coll", 9'h004, 1, PEND_ADDR, 8'h04, 0, 0, 8'h17, 2'd1, 8'h04));
    step(mk("svc_hold", 9'h000, 0, PEND_ADDR, 8'h00, 0, 0, 8'h17, 2'd1, 8'h04));
    step(mk("svc_clr",  9'h000, 1, PEND_ADDR, 8'h04, 0, 0, 8'h17, 2'd1, 8'h00));
    step(mk("svc_out",  9'h000, 0, PEND_ADDR, 8'h00, 0, 0, 8'h17, 2'd1, 8'h00));
    step(mk("svc_idle", 9'h000, 0, PEND_ADDR, 8'h00, 0, 0, 8'h17, 2'd1, 8'h00));

    // Set/clear collision on key 0 while masked, and clock-enable gating.
    step(mk("k0_en00",  9'h000, 1, EN_ADDR,   8'h00, 0, 0, 8'h17, 2'd1, 8'h00));
    step(mk("k0_set",   9'h001, 0, PEND_ADDR, 8'h00, 0, 0, 8'h17, 2'd1, 8'h01));
    step(mk("k0_coll",  9'h001, 1, PEND_ADDR, 8'h01, 0, 0, 8'h17, 2'd1, 8'h01));
    step(mk("k0_clr",   9'h000, 1, PEND_ADDR, 8'h01, 0, 0, 8'h17, 2'd1, 8'h00));
    v = mk("ce_low",    9'h080, 1, PEND_ADDR, 8'h00, 0, 0, 8'h17, 2'd1, 8'h00);
    v.ce = 1'b0;
    step(v);

    // Asynchronous reset in the middle of a request.
    step(mk("rs_en",    9'h000, 1, EN_ADDR,   8'hFF, 0, 0, 8'h17, 2'd1, 8'hFF));
    step(mk("rs_key6",  9'h040, 0, PEND_ADDR, 8'h00, 0, 0, 8'h17, 2'd1, 8'h40));
    step(mk("rs_req6",  9'h000, 0, PEND_ADDR, 8'h00, 0, 1, 8'h1B, 2'd1, 8'h40));
    reset = 1'b1;
    #1;
    chk("async_rst", "irq_req", {7'd0, irq_req}, 8'h00);
    chk("async_rst", "irq_vector", irq_vector, 8'h00);
    chk("async_rst", "irq_level", {6'd0, irq_level}, 8'h00);
    read_chk("rst_en", EN_ADDR, 8'h00);
    read_chk("rst_cfg", CFG_ADDR, 8'h00);
    read_chk("rst_pend", PEND_ADDR, 8'h00);
    read_chk("rst_pend_hi", PEND_HI_ADDR, 8'h00);
    @(posedge clk); #1 reset = 1'b0;
    step(mk("ack_idle", 9'h000, 0, 24'h0,     8'h00, 1, 0, 8'h00, 2'd0, 8'h00));

`ifdef KEY_IRQ_LOCKOUT_EN
    step(mk("lo_t0",    9'h010, 0, PEND_ADDR, 8'h00, 0, 0, 8'h00, 2'd0, 8'h10));
    step(mk("lo_t1",    9'h000, 1, PEND_ADDR, 8'h10, 0, 0, 8'h00, 2'd0, 8'h00));
    step(mk("lo_t2",    9'h010, 0, PEND_ADDR, 8'h00, 0, 0, 8'h00, 2'd0, 8'h00));
    step(mk("lo_t3",    9'h000, 0, PEND_ADDR, 8'h00, 0, 0, 8'h00, 2'd0, 8'h00));
    step(mk("lo_t4",    9'h010, 0, PEND_ADDR, 8'h00, 0, 0, 8'h00, 2'd0, 8'h10));
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
